branch_predict_unit: RTL

Parametrised branch unit that resolves conditional branches and jumps in the execute stage, and owns a bimodal branch history table (BHT) of 2-bit saturating counters that supplies taken/not-taken predictions to fetch. Resolution uses the ALU's XOR/SLT/SLTU result plus the RISC-V funct3 compare code. Resolution emits the PC-mux select, a mispredict flush request and a table update. Saturating statistics counters track resolved branches and mispredicts.

---
 rtl/branch_predict_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolver with a bimodal 2-bit BHT feeding fetch predictions.
// Tracks saturating counts of resolved conditional branches and mispredicts.
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_IDX_W = 6,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_req,
   input  logic [XLEN-1:0]   pred_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic [XLEN-1:0]   res_pc,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [2:0]        cmp_opcode,
   input  logic              pc_jump,
   input  logic              res_pred_taken,
   output logic [1:0]        branch,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int N = 1 << BHT_IDX_W;

   logic [1:0]           bht_q [N];
   logic [1:0]           bht_d [N];
   logic                 pred_valid_q, pred_valid_d;
   logic                 pred_taken_q, pred_taken_d;
   logic [STAT_W-1:0]    stat_br_q, stat_br_d;
   logic [STAT_W-1:0]    stat_mp_q, stat_mp_d;

   logic [BHT_IDX_W-1:0] pred_idx;
   logic [BHT_IDX_W-1:0] res_idx;
   logic                 zero;
   logic                 lt;
   logic                 taken;
   logic                 cmp_ok;
   logic                 upd;
   logic [1:0]           ctr;

   assign pred_idx = pred_pc[BHT_IDX_W+1:2];
   assign res_idx  = res_pc[BHT_IDX_W+1:2];

   always_comb begin
      zero   = (alu_result == '0);
      lt     = alu_result[0];
      taken  = 1'b0;
      cmp_ok = 1'b1;
      case (cmp_opcode)
         3'b000:         taken = zero;
         3'b001:         taken = !zero;
         3'b100, 3'b110: taken = lt;
         3'b101, 3'b111: taken = !lt;
         default:        cmp_ok = 1'b0;
      endcase
   end

   always_comb begin
      if (pc_jump)
         branch = 2'b10;
      else if (res_valid)
         branch = {1'b0, taken};
      else
         branch = 2'b00;
      mispredict = res_valid & !pc_jump & (taken != res_pred_taken);
      upd        = res_valid & !pc_jump & cmp_ok;
   end

   always_comb begin
      bht_d = bht_q;
      ctr   = bht_q[res_idx];
      if (upd) begin
         if (taken)
            bht_d[res_idx] = (ctr == 2'b11) ? ctr : ctr + 2'd1;
         else
            bht_d[res_idx] = (ctr == 2'b00) ? ctr : ctr - 2'd1;
      end
      // Reading the next-state table gives write-first bypass on collisions
      pred_valid_d = pred_req;
      pred_taken_d = pred_req ? bht_d[pred_idx][1] : pred_taken_q;
      stat_br_d    = stat_br_q;
      stat_mp_d    = stat_mp_q;
      if (upd && stat_br_q != '1)
         stat_br_d = stat_br_q + 1'b1;
      if (upd && mispredict && stat_mp_q != '1)
         stat_mp_d = stat_mp_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            bht_q[i] <= 2'b01;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         stat_br_q    <= '0;
         stat_mp_q    <= '0;
      end else begin
         bht_q        <= bht_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         stat_br_q    <= stat_br_d;
         stat_mp_q    <= stat_mp_d;
      end
   end

   assign pred_valid    = pred_valid_q;
   assign pred_taken    = pred_taken_q;
   assign stat_branches = stat_br_q;
   assign stat_mispred  = stat_mp_q;

   logic unused_ok;
   assign unused_ok = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0],
                        res_pc[XLEN-1:BHT_IDX_W+2], res_pc[1:0]};

endmodule
